// File: rtl/jtopll_mmr.sv
// jtopll_mmr: host bus front end for the OPLL register file.
// Captures address/data port writes, decodes the register map, and holds
// channel update strobes for one full slot round aligned to the zero pulse.
module jtopll_mmr #(
   parameter int ADDR_WAIT = 12,
   parameter int SLOTS     = 18
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cen,
   input  logic       cs_n,
   input  logic       wr_n,
   input  logic       addr,
   input  logic [7:0] din,
   input  logic       zero,
   output logic [7:0] dout,
   output logic [1:0] sel_group,
   output logic [2:0] sel_sub,
   output logic       up_fnumlo,
   output logic       up_fnumhi,
   output logic       up_inst,
   output logic       up_original,
   output logic       rhy_en,
   output logic [4:0] rhy_kon,
   output logic       busy
);

   localparam int BW = $clog2(ADDR_WAIT + 1);
   localparam int HW = $clog2(SLOTS + 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_ZERO = 2'd1,
      HOLD      = 2'd2
   } state_t;

   state_t          state_reg, state_next;
   logic            wr_prev_reg;
   logic [7:0]      addr_reg;
   logic [BW-1:0]   busy_cnt_reg;
   logic [HW-1:0]   hold_cnt_reg;
   logic [1:0]      kind_reg;       // 0 = fnum low, 1 = fnum high, 2 = inst/vol

   logic            wr_event;
   logic            addr_wr;
   logic            data_wr;
   logic [3:0]      ch;
   logic [3:0]      hi;
   logic            is_patch;
   logic            is_rhy;
   logic            is_chan;
   logic [1:0]      ch_group;
   logic [2:0]      ch_sub;
   logic [2:0]      strobe;

   // A write is the first cycle of an asserted cs_n/wr_n pair; holding it low gives one event.
   assign wr_event = ~cs_n & ~wr_n & ~wr_prev_reg;
   assign addr_wr  = wr_event & ~addr;
   // Data writes are only honoured while no channel update is pending.
   assign data_wr  = wr_event & addr & (state_reg == IDLE);

   assign ch       = addr_reg[3:0];
   assign hi       = addr_reg[7:4];
   assign is_patch = (addr_reg[7:3] == 5'd0);
   assign is_rhy   = (addr_reg == 8'h0E);
   assign is_chan  = ((hi == 4'd1) || (hi == 4'd2) || (hi == 4'd3)) && (ch <= 4'd8);

   // Split the channel number into group (ch/3) and subslot (ch%3).
   always_comb begin
      ch_group = 2'd0;
      ch_sub   = 3'd0;
      case (ch)
         4'd0: begin ch_group = 2'd0; ch_sub = 3'd0; end
         4'd1: begin ch_group = 2'd0; ch_sub = 3'd1; end
         4'd2: begin ch_group = 2'd0; ch_sub = 3'd2; end
         4'd3: begin ch_group = 2'd1; ch_sub = 3'd0; end
         4'd4: begin ch_group = 2'd1; ch_sub = 3'd1; end
         4'd5: begin ch_group = 2'd1; ch_sub = 3'd2; end
         4'd6: begin ch_group = 2'd2; ch_sub = 3'd0; end
         4'd7: begin ch_group = 2'd2; ch_sub = 3'd1; end
         4'd8: begin ch_group = 2'd2; ch_sub = 3'd2; end
         default: begin ch_group = 2'd0; ch_sub = 3'd0; end
      endcase
   end

   // Write edge detector and address latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_prev_reg <= 1'b0;
         addr_reg    <= 8'd0;
      end else begin
         wr_prev_reg <= ~cs_n & ~wr_n;
         if (addr_wr)
            addr_reg <= din;
      end
   end

   // Address-port busy window: reload on every address write, count down on cen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         busy_cnt_reg <= '0;
      else if (addr_wr)
         busy_cnt_reg <= BW'(ADDR_WAIT);
      else if (cen && (busy_cnt_reg != '0))
         busy_cnt_reg <= busy_cnt_reg - 1'b1;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // FSM next state: a zero pulse is only seen once WAIT_ZERO is entered, so a
   // zero coincident with the capture cycle is skipped.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:      if (data_wr && is_chan)             state_next = WAIT_ZERO;
         WAIT_ZERO: if (cen && zero)                     state_next = HOLD;
         HOLD:      if (cen && (hold_cnt_reg == '0))     state_next = IDLE;
         default:                                        state_next = IDLE;
      endcase
   end

   // Hold counter: one full slot round of cen ticks once HOLD starts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         hold_cnt_reg <= '0;
      else if ((state_reg == WAIT_ZERO) && (state_next == HOLD))
         hold_cnt_reg <= HW'(SLOTS - 1);
      else if ((state_reg == HOLD) && cen && (hold_cnt_reg != '0))
         hold_cnt_reg <= hold_cnt_reg - 1'b1;
   end

   // Data capture into the forwarded byte and selectors; patch writes pulse up_original.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout        <= 8'd0;
         sel_group   <= 2'd0;
         sel_sub     <= 3'd0;
         kind_reg    <= 2'd0;
         up_original <= 1'b0;
      end else begin
         up_original <= 1'b0;
         if (data_wr && is_patch) begin
            dout        <= din;
            sel_sub     <= addr_reg[2:0];
            up_original <= 1'b1;
         end else if (data_wr && is_chan) begin
            dout      <= din;
            sel_group <= ch_group;
            sel_sub   <= ch_sub;
            kind_reg  <= 2'(hi - 4'd1);
         end
      end
   end

   // Rhythm control register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rhy_en  <= 1'b0;
         rhy_kon <= 5'd0;
      end else if (data_wr && is_rhy) begin
         rhy_en  <= din[5];
         rhy_kon <= din[4:0];
      end
   end

   // One strobe per register kind, active for the whole HOLD window.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_strobe
         assign strobe[gi] = (state_reg == HOLD) && (kind_reg == 2'(gi));
      end
   endgenerate

   assign up_fnumlo = strobe[0];
   assign up_fnumhi = strobe[1];
   assign up_inst   = strobe[2];

   assign busy = (busy_cnt_reg != '0) || (state_reg != IDLE);

endmodule

// File: tb/tb_jtopll_mmr.sv
// tb_jtopll_mmr: directed bench for the OPLL register front end.
module tb_jtopll_mmr;

   logic       clk;
   logic       rst_n;
   logic       cen;
   logic       cs_n;
   logic       wr_n;
   logic       addr;
   logic [7:0] din;
   logic       zero;
   logic [7:0] dout;
   logic [1:0] sel_group;
   logic [2:0] sel_sub;
   logic       up_fnumlo;
   logic       up_fnumhi;
   logic       up_inst;
   logic       up_original;
   logic       rhy_en;
   logic [4:0] rhy_kon;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   jtopll_mmr #(.ADDR_WAIT(12), .SLOTS(18)) dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .cs_n(cs_n), .wr_n(wr_n),
      .addr(addr), .din(din), .zero(zero), .dout(dout),
      .sel_group(sel_group), .sel_sub(sel_sub),
      .up_fnumlo(up_fnumlo), .up_fnumhi(up_fnumhi), .up_inst(up_inst),
      .up_original(up_original), .rhy_en(rhy_en), .rhy_kon(rhy_kon),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic clk_step();
      @(posedge clk);
      #1;
   endtask

   // Assert the write strobe for one cycle; returns in the cycle after the event.
   task automatic strobe_wr(input logic a, input logic [7:0] d);
      cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
      clk_step();
      cs_n = 1'b1; wr_n = 1'b1;
   endtask

   task automatic bus_write(input logic a, input logic [7:0] d);
      strobe_wr(a, d);
      clk_step();
   endtask

   task automatic cen_tick(input logic z);
      cen = 1'b1; zero = z;
      clk_step();
      cen = 1'b0; zero = 1'b0;
      clk_step();
   endtask

   int hi_cnt;
   int gap_cnt;
   int lo_seen;

   initial begin
      rst_n = 1'b0; cen = 1'b0; cs_n = 1'b1; wr_n = 1'b1;
      addr = 1'b0; din = 8'd0; zero = 1'b0;
      clk_step(); clk_step();
      rst_n = 1'b1;
      clk_step();

      // Reset state
      check_val("rst_busy", busy, 0);
      check_val("rst_strobes", {up_fnumlo, up_fnumhi, up_inst, up_original}, 0);
      check_val("rst_dout", dout, 0);
      check_val("rst_rhy", {rhy_en, rhy_kon}, 0);

      // Channel 5 fnum-high update: group 1, subslot 2
      bus_write(1'b0, 8'h25);
      check_val("A_busy_addr", busy, 1);
      bus_write(1'b1, 8'h3A);
      check_val("A_dout", dout, 8'h3A);
      check_val("A_sel_group", sel_group, 1);
      check_val("A_sel_sub", sel_sub, 2);
      for (int i = 0; i < 4; i++) cen_tick(1'b0);
      check_val("A_wait_strobe", up_fnumhi, 0);
      check_val("A_wait_busy", busy, 1);
      cen = 1'b1; zero = 1'b1;
      clk_step();
      check_val("A_rise", up_fnumhi, 1);
      cen = 1'b0; zero = 1'b0;
      clk_step();
      hi_cnt = 0; gap_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (up_fnumhi) hi_cnt++;
         if (up_fnumhi && !busy) gap_cnt++;
         cen_tick(1'b0);
      end
      check_val("A_hold_ticks", hi_cnt, 18);
      check_val("A_busy_gap", gap_cnt, 0);
      check_val("A_fall", up_fnumhi, 0);
      check_val("A_busy_end", busy, 0);

      // Patch byte write: one-clock up_original pulse, address busy window of 12 cen
      bus_write(1'b0, 8'h03);
      check_val("B_busy_addr", busy, 1);
      for (int i = 0; i < 11; i++) cen_tick(1'b0);
      check_val("B_busy_11", busy, 1);
      cen_tick(1'b0);
      check_val("B_busy_12", busy, 0);
      strobe_wr(1'b1, 8'h7F);
      check_val("B_orig_pulse", up_original, 1);
      check_val("B_dout", dout, 8'h7F);
      check_val("B_sel_sub", sel_sub, 3);
      check_val("B_sel_group", sel_group, 1);
      check_val("B_busy_data", busy, 0);
      clk_step();
      check_val("B_orig_end", up_original, 0);

      // Rhythm register
      bus_write(1'b0, 8'h0E);
      strobe_wr(1'b1, 8'h3F);
      check_val("C_rhy_set", {rhy_en, rhy_kon}, 6'h3F);
      clk_step();
      strobe_wr(1'b1, 8'h00);
      check_val("C_rhy_clr", {rhy_en, rhy_kon}, 0);
      clk_step();

      // Ignored addresses
      bus_write(1'b0, 8'h19);
      for (int i = 0; i < 12; i++) cen_tick(1'b0);
      bus_write(1'b1, 8'h44);
      check_val("D19_busy", busy, 0);
      cen_tick(1'b1); cen_tick(1'b1);
      check_val("D19_strobes", {up_fnumlo, up_fnumhi, up_inst, up_original}, 0);
      check_val("D19_dout", dout, 8'h7F);
      bus_write(1'b0, 8'h0F);
      for (int i = 0; i < 12; i++) cen_tick(1'b0);
      bus_write(1'b1, 8'h25);
      check_val("D0F_busy", busy, 0);
      check_val("D0F_rhy", {rhy_en, rhy_kon}, 0);
      check_val("D0F_dout_sel", {dout, sel_group, sel_sub}, {8'h7F, 2'd1, 3'd3});

      // Inst write with zero coincident on the capture cycle, then a dropped write in HOLD
      bus_write(1'b0, 8'h30);
      cs_n = 1'b0; wr_n = 1'b0; addr = 1'b1; din = 8'h12; cen = 1'b1; zero = 1'b1;
      clk_step();
      cs_n = 1'b1; wr_n = 1'b1; cen = 1'b0; zero = 1'b0;
      clk_step();
      check_val("E_coinc_zero", up_inst, 0);
      check_val("E_dout", dout, 8'h12);
      cen_tick(1'b0); cen_tick(1'b0);
      check_val("E_still_wait", up_inst, 0);
      cen_tick(1'b1);
      check_val("E_rise", up_inst, 1);
      bus_write(1'b0, 8'h10);
      bus_write(1'b1, 8'h55);
      check_val("E_drop_dout", dout, 8'h12);
      check_val("E_drop_sel", {sel_group, sel_sub}, 0);
      hi_cnt = 0; lo_seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (up_inst) hi_cnt++;
         if (up_fnumlo) lo_seen++;
         cen_tick(1'b0);
      end
      cen_tick(1'b1); cen_tick(1'b1);
      if (up_fnumlo) lo_seen++;
      check_val("E_hold_ticks", hi_cnt, 18);
      check_val("E_no_fnumlo", lo_seen, 0);
      check_val("E_dout_end", dout, 8'h12);

      // Asynchronous reset in the middle of HOLD
      bus_write(1'b0, 8'h0E);
      bus_write(1'b1, 8'h3F);
      bus_write(1'b0, 8'h11);
      bus_write(1'b1, 8'hAA);
      cen_tick(1'b1);
      check_val("F_in_hold", up_fnumlo, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("F_rst_strobes", {up_fnumlo, up_fnumhi, up_inst, up_original}, 0);
      check_val("F_rst_busy", busy, 0);
      check_val("F_rst_rhy", {rhy_en, rhy_kon}, 0);
      check_val("F_rst_data", {dout, sel_group, sel_sub}, 0);
      clk_step();
      rst_n = 1'b1;
      clk_step();
      cen_tick(1'b1);
      check_val("F_after_busy", busy, 0);
      check_val("F_after_strobe", up_fnumlo, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
